cmp_arbiter: RTL and testbench
==============================

# cmp_arbiter

Round-robin arbiter and sequencer that shares a single W-bit magnitude comparator among NREQ requesters. Each requester holds a request with its operand pair. The arbiter grants one requester at a time, latches that requester's operands and compares them. It then returns the greater/equal/less flags with a one-cycle acknowledge. It sits between the client blocks and the comparator datapath, so only one comparator instance is needed in the design.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, operand width in bits

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- req  in  NREQ  request per requester; held high until its ack
- a_in  in  NREQ*W  operand A, requester i in bits [i*W +: W]
- b_in  in  NREQ*W  operand B, same packing
- ack  out  NREQ  one-hot, one-cycle pulse that returns the result to requester resp_id
- a_g_b  out  1  A > B, valid only while ack != 0
- a_e_b  out  1  A == B, valid only while ack != 0
- a_l_b  out  1  A < B, valid only while ack != 0
- resp_id  out  clog2(NREQ)  index of the requester being served
- busy  out  1  high in CMP and ACK
- done_cnt  out  8  completed comparisons, wraps 255 -> 0

## Operation
- FSM states: IDLE, CMP, ACK.
- IDLE:
  - If any req bit is high, select the winner by round-robin. Search starts at last_id+1 mod NREQ.
  - Latch a_in/b_in slices of the winner into op_a/op_b. Latch the winner index into resp_id. Go to CMP.
  - Otherwise stay in IDLE.
- CMP:
  - Comparator evaluates op_a vs op_b.
  - Register the three flags; exactly one is high.
  - Go to ACK.
- ACK:
  - ack[resp_id] = 1 with flags stable.
  - last_id <= resp_id; done_cnt <= done_cnt + 1 (mod 256).
  - Go to IDLE.
- Requester protocol:
  - Keep req and operands stable from assertion until ack is seen.
  - Drop req on the clock edge that samples ack; the arbiter never re-serves the same request.
  - Operand changes while req is high and not yet granted are legal. Values are captured only in the IDLE grant cycle.
- Flags and ack are 0 outside ACK.
- A requester's req dropping after grant does not abort the transaction; ack is still issued.

## Timing
- Reset (rst_n low at a rising edge) gives:
  - state=IDLE, ack=0, flags=0, resp_id=0, busy=0, done_cnt=0.
  - last_id=NREQ-1, so requester 0 has first priority.
- Reset mid-operation abandons the in-flight compare; no ack is issued for it.
- Latency: req sampled high in IDLE at cycle t -> CMP at t+1 -> ack at t+2.
- Throughput: one comparison per 3 cycles under continuous load.
- Simultaneous requests: round-robin order from last_id+1.
  - All NREQ requesters are served within 3*NREQ cycles.
  - No requester is granted twice while another waits.
- A req rising during CMP/ACK waits for the next IDLE.
- done_cnt increments in the ACK cycle and wraps silently.

## Configuration
- CMP_ARB_SIGNED_EN defined: operands compared as W-bit two's complement.
- Undefined: operands compared as unsigned.
- Handshake and latency are identical in both modes.

## Structure
- Shared package cmp_arb_pkg holds:
  - the state enum (IDLE, CMP, ACK)
  - the flag-bundle typedef (gt, eq, lt)
  - the reset constant for last_id
- One sub-module, magnitude_cmp: purely combinational W-bit comparator producing gt/eq/lt. Signedness is selected by CMP_ARB_SIGNED_EN.
- The round-robin priority search is a function inside cmp_arbiter.

## Test plan
- Single requester: req[0] with A=0001, B=0100 -> ack[0] exactly 2 cycles later, a_l_b=1, resp_id=0, done_cnt=1.
- Three in sequence on requester 2: A=1111/B=1011 -> a_g_b=1; then 0000/0000 -> a_e_b=1; then 0001/1000 -> a_l_b=1 unsigned, a_g_b=1 with CMP_ARB_SIGNED_EN.
- All 4 requesters raise req in the same cycle from reset -> acks in order 0,1,2,3 at cycles 2,5,8,11; busy stays high except the IDLE cycles.
- Fairness: req[1] held continuously (re-raised after each ack) plus req[3] -> acks alternate 1,3,1,3.
- rst_n pulsed low during CMP -> no ack, all outputs at reset values next cycle; the still-high request is then served normally with ack 2 cycles after reset release.
- 256 back-to-back completions -> done_cnt wraps to 0 on the 256th ack.

Source files
------------

// File: rtl/cmp_arb_pkg.sv
// Shared types for the comparator arbiter: FSM states, the result flag bundle
// and the reset value of the round-robin pointer.
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } flags_t;

  // Pointer starts at the last requester so requester 0 wins first after reset
  function automatic int lastIdReset(input int nreq);
    return nreq - 1;
  endfunction

endpackage

// File: rtl/cmp_arbiter_magnitude_cmp.sv
// Purely combinational W-bit magnitude comparator producing one-hot gt/eq/lt.
// Defining CMP_ARB_SIGNED_EN compares the operands as two's complement.
module magnitude_cmp
  import cmp_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output flags_t       o_flags
);

  always_comb begin
    o_flags = '0;
`ifdef CMP_ARB_SIGNED_EN
    if ($signed(i_a) > $signed(i_b))
      o_flags.gt = 1'b1;
    else if (i_a == i_b)
      o_flags.eq = 1'b1;
    else
      o_flags.lt = 1'b1;
`else
    if (i_a > i_b)
      o_flags.gt = 1'b1;
    else if (i_a == i_b)
      o_flags.eq = 1'b1;
    else
      o_flags.lt = 1'b1;
`endif
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters:
// grant in IDLE, compare in CMP, one-cycle ack in ACK. Signedness via CMP_ARB_SIGNED_EN.
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        a_in,
  input  logic [NREQ*W-1:0]        b_in,
  output logic [NREQ-1:0]          ack,
  output logic                     a_g_b,
  output logic                     a_e_b,
  output logic                     a_l_b,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic                     busy,
  output logic [7:0]               done_cnt
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_ID_RST = IDW'(lastIdReset(NREQ));

  state_t         r_state;
  state_t         w_nextState;
  logic [W-1:0]   r_opA;
  logic [W-1:0]   r_opB;
  logic [IDW-1:0] r_respId;
  logic [IDW-1:0] r_lastId;
  logic [IDW-1:0] w_winner;
  logic [W-1:0]   w_selA;
  logic [W-1:0]   w_selB;
  flags_t         r_flags;
  flags_t         w_cmpFlags;
  flags_t         w_outFlags;
  logic [7:0]     r_doneCnt;
  logic           w_anyReq;

  // Scan from farthest to nearest after last, so the nearest requester wins
  function automatic logic [IDW-1:0] rrPick(input logic [NREQ-1:0] reqs,
                                            input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    int             idx;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (reqs[idx])
        pick = IDW'(idx);
    end
    return pick;
  endfunction

  assign w_anyReq = |req;
  assign w_winner = rrPick(req, r_lastId);

  always_comb begin
    w_selA = '0;
    w_selB = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_selA = a_in[i*W +: W];
        w_selB = b_in[i*W +: W];
      end
    end
  end

  magnitude_cmp #(.W(W)) u_cmp (
    .i_a     (r_opA),
    .i_b     (r_opB),
    .o_flags (w_cmpFlags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    ack         = '0;
    w_outFlags  = '0;
    case (r_state)
      IDLE: if (w_anyReq) w_nextState = CMP;
      CMP:  w_nextState = ACK;
      ACK: begin
        w_nextState   = IDLE;
        ack[r_respId] = 1'b1;
        w_outFlags    = r_flags;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand capture happens only on the grant cycle; later operand changes are ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opA     <= '0;
      r_opB     <= '0;
      r_respId  <= '0;
      r_lastId  <= LAST_ID_RST;
      r_flags   <= '0;
      r_doneCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_opA    <= w_selA;
            r_opB    <= w_selB;
            r_respId <= w_winner;
          end
        end
        CMP: r_flags <= w_cmpFlags;
        ACK: begin
          r_lastId  <= r_respId;
          r_doneCnt <= r_doneCnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign a_g_b    = w_outFlags.gt;
  assign a_e_b    = w_outFlags.eq;
  assign a_l_b    = w_outFlags.lt;
  assign resp_id  = r_respId;
  assign busy     = (r_state != IDLE);
  assign done_cnt = r_doneCnt;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: table of single-requester compares plus
// sequences for simultaneous requests, fairness, mid-compare reset and counter wrap.
module tb_cmp_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   ack;
  logic              a_g_b;
  logic              a_e_b;
  logic              a_l_b;
  logic [1:0]        resp_id;
  logic              busy;
  logic [7:0]        done_cnt;

  int errors;
  int checks;

  cmp_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .ack      (ack),
    .a_g_b    (a_g_b),
    .a_e_b    (a_e_b),
    .a_l_b    (a_l_b),
    .resp_id  (resp_id),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags are packed {gt, eq, lt}; expected values depend on operand signedness
  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] expU;
    logic [2:0] expS;
  } vec_t;

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request on requester id; returns what was observed at ack and the cycle after
  task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                               output int lat, output logic [NREQ-1:0] ackV,
                               output logic [1:0] rid, output logic [2:0] flg,
                               output logic [7:0] doneAfter, output logic [6:0] idleOut,
                               output logic bsyAfter);
    a_in[id*W +: W] = a;
    b_in[id*W +: W] = b;
    req[id]         = 1'b1;
    lat  = -1;
    ackV = '0;
    rid  = '0;
    flg  = '0;
    for (int n = 1; n <= 10; n++) begin
      stepClock();
      if (ack != '0) begin
        lat  = n;
        ackV = ack;
        rid  = resp_id;
        flg  = {a_g_b, a_e_b, a_l_b};
        break;
      end
    end
    req[id] = 1'b0;
    stepClock();
    doneAfter = done_cnt;
    idleOut   = {ack, a_g_b, a_e_b, a_l_b};
    bsyAfter  = busy;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t             vecs[7];
    logic [2:0]       expF;
    int               lat;
    logic [NREQ-1:0]  ackV;
    logic [1:0]       rid;
    logic [2:0]       flg;
    logic [7:0]       doneAfter;
    logic [6:0]       idleOut;
    logic             bsyAfter;
    logic [7:0]       expDone;
    logic [NREQ-1:0]  expAck;
    logic [2:0]       allFlags[NREQ];
    logic [NREQ-1:0]  reraise;
    logic [NREQ-1:0]  ackOrder[4];
    int               nAcks;
    int               badLat;

    errors = 0;
    checks = 0;

    vecs[0] = '{id: 0, a: 4'b0001, b: 4'b0100, expU: 3'b001, expS: 3'b001};
    vecs[1] = '{id: 2, a: 4'b1111, b: 4'b1011, expU: 3'b100, expS: 3'b100};
    vecs[2] = '{id: 2, a: 4'b0000, b: 4'b0000, expU: 3'b010, expS: 3'b010};
    vecs[3] = '{id: 2, a: 4'b0001, b: 4'b1000, expU: 3'b001, expS: 3'b100};
    vecs[4] = '{id: 1, a: 4'b0111, b: 4'b0111, expU: 3'b010, expS: 3'b010};
    vecs[5] = '{id: 3, a: 4'b1000, b: 4'b0111, expU: 3'b100, expS: 3'b001};
    vecs[6] = '{id: 0, a: 4'b1100, b: 4'b1101, expU: 3'b001, expS: 3'b001};

    req   = '0;
    a_in  = '0;
    b_in  = '0;
    rst_n = 1'b0;
    stepClock();
    stepClock();
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_flags", {a_g_b, a_e_b, a_l_b}, 0);
    checkOutput("reset_resp_id", resp_id, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done_cnt", done_cnt, 0);
    rst_n = 1'b1;

    expDone = 8'd0;
    for (int i = 0; i < 7; i++) begin
`ifdef CMP_ARB_SIGNED_EN
      expF = vecs[i].expS;
`else
      expF = vecs[i].expU;
`endif
      applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, lat, ackV, rid, flg, doneAfter, idleOut, bsyAfter);
      expDone = expDone + 8'd1;
      checkOutput($sformatf("vec%0d_latency", i), lat, 2);
      checkOutput($sformatf("vec%0d_ack", i), ackV, 1 << vecs[i].id);
      checkOutput($sformatf("vec%0d_resp_id", i), rid, vecs[i].id);
      checkOutput($sformatf("vec%0d_flags", i), flg, expF);
      checkOutput($sformatf("vec%0d_done_cnt", i), doneAfter, expDone);
      checkOutput($sformatf("vec%0d_idle_outputs", i), idleOut, 0);
      checkOutput($sformatf("vec%0d_idle_busy", i), bsyAfter, 0);
    end

    // All four requesters at once straight out of reset
    rst_n = 1'b0;
    stepClock();
    rst_n = 1'b1;
    a_in = {4'd7, 4'd1, 4'd5, 4'd3};
    b_in = {4'd7, 4'd6, 4'd2, 4'd3};
    allFlags[0] = 3'b010;
    allFlags[1] = 3'b100;
    allFlags[2] = 3'b001;
    allFlags[3] = 3'b010;
    req = 4'b1111;
    for (int c = 1; c <= 12; c++) begin
      stepClock();
      expAck = (c % 3 == 2) ? NREQ'(1 << ((c - 2) / 3)) : '0;
      checkOutput($sformatf("all4_c%0d_ack", c), ack, expAck);
      checkOutput($sformatf("all4_c%0d_busy", c), busy, (c % 3 != 0));
      if (expAck != '0) begin
        checkOutput($sformatf("all4_c%0d_resp_id", c), resp_id, (c - 2) / 3);
        checkOutput($sformatf("all4_c%0d_flags", c), {a_g_b, a_e_b, a_l_b}, allFlags[(c - 2) / 3]);
      end
      req = req & ~ack;
    end
    req = '0;

    // Fairness: requesters 1 and 3 re-raise right after each ack
    req     = 4'b1010;
    reraise = '0;
    nAcks   = 0;
    for (int c = 1; c <= 30 && nAcks < 4; c++) begin
      stepClock();
      req     = req | reraise;
      reraise = '0;
      if (ack != '0) begin
        ackOrder[nAcks] = ack;
        nAcks++;
        req     = req & ~ack;
        reraise = ack;
      end
    end
    req = '0;
    stepClock();
    checkOutput("fair_ack_count", nAcks, 4);
    for (int i = 0; i < 4; i++)
      if (i < nAcks)
        checkOutput($sformatf("fair_ack%0d", i), ackOrder[i], (i % 2 == 0) ? 4'b0010 : 4'b1000);

    // Reset while a compare is in flight
    a_in[2*W +: W] = 4'd2;
    b_in[2*W +: W] = 4'd9;
    req[2] = 1'b1;
    stepClock();
    checkOutput("rst_mid_busy_cmp", busy, 1);
    rst_n = 1'b0;
    stepClock();
    checkOutput("rst_mid_ack", ack, 0);
    checkOutput("rst_mid_flags", {a_g_b, a_e_b, a_l_b}, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_resp_id", resp_id, 0);
    checkOutput("rst_mid_done_cnt", done_cnt, 0);
    rst_n = 1'b1;
    lat  = -1;
    ackV = '0;
    flg  = '0;
    for (int n = 1; n <= 10; n++) begin
      stepClock();
      if (ack != '0) begin
        lat  = n;
        ackV = ack;
        flg  = {a_g_b, a_e_b, a_l_b};
        break;
      end
    end
    req[2] = 1'b0;
    stepClock();
    checkOutput("rst_mid_reserve_latency", lat, 2);
    checkOutput("rst_mid_reserve_ack", ackV, 4'b0100);
    checkOutput("rst_mid_reserve_flags", flg, 3'b001);
    checkOutput("rst_mid_reserve_done_cnt", done_cnt, 1);

    // 256 completions wrap the counter back to zero
    rst_n = 1'b0;
    stepClock();
    rst_n  = 1'b1;
    badLat = 0;
    for (int i = 0; i < 255; i++) begin
      applyStimulus(i % NREQ, 4'(i), 4'(i + 3), lat, ackV, rid, flg, doneAfter, idleOut, bsyAfter);
      if (lat != 2)
        badLat++;
    end
    checkOutput("wrap_latency_errors", badLat, 0);
    checkOutput("wrap_done_cnt_255", doneAfter, 255);
    applyStimulus(3, 4'd1, 4'd1, lat, ackV, rid, flg, doneAfter, idleOut, bsyAfter);
    checkOutput("wrap_last_flags", flg, 3'b010);
    checkOutput("wrap_done_cnt_0", doneAfter, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
